spi_sclk_gen: RTL and testbench

- Parametrised SPI serial-clock engine for the nRF24L01 link on the DE10-Lite; successor to the fixed 50→10 MHz divider.
- Generates SCLK with a runtime-programmable half-period and CPOL/CPHA mode, for a programmed number of bit-cycles per burst.
- Emits one-cycle shift/sample strobes to the byte shift register, plus a start/busy/done handshake toward the command FSM.

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_half_period_counter.sv | 47 ++++
 rtl/spi_sclk_gen.sv | 186 ++++++++++++++++++
 tb/tb_spi_sclk_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI serial-clock engine (nRF24L01 link, DE10-Lite).
//   - spi_state_e      : burst engine state (IDLE, RUN, TAIL)
//   - SPI_MODE0..3     : SPI modes encoded as {cpol, cpha}
//   - SPI_CNT_W_DEF    : default half-period counter width
//   - SPI_BITS_W_DEF   : default bit-count width
//   - SPI_SYS_CLK_HZ   : system clock frequency (50 MHz)
//   - spi_half_div_for : smallest half_div whose SCLK does not exceed target_hz
//                        (10 MHz -> 3; half_div=2 would give 12.5 MHz)
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } spi_state_e;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int SPI_CNT_W_DEF  = 8;
    localparam int SPI_BITS_W_DEF = 6;

    localparam int SPI_SYS_CLK_HZ = 50_000_000;

    // Rounds up so the generated SCLK never exceeds the target frequency.
    function automatic int spi_half_div_for(input int target_hz);
        return (SPI_SYS_CLK_HZ + 2 * target_hz - 1) / (2 * target_hz);
    endfunction

endpackage

// File: rtl/spi_half_period_counter.sv
// -----------------------------------------------------------------------------
// spi_half_period_counter
// Reloadable up-counter timing one SCLK half-period. Counts 0..last and
// reloads to 0 on terminal count.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   clr        : synchronous load to 0 (held while the engine is idle)
//   en         : count enable
//   last       : terminal value (half-period length minus one)
//   tc         : terminal count, high while enabled and count == last
// -----------------------------------------------------------------------------
module spi_half_period_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] last,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = en && (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tc) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// SPI serial-clock engine: generates SCLK with programmable half-period and
// CPOL/CPHA mode for nbits clock cycles per burst, with one-cycle shift/sample
// strobes and a start/busy/done handshake. All outputs are registered.
// Optional feature macro: SPI_SCLK_ABORT_EN adds the abort input, which ends
// a running burst at the next clock edge with a done pulse.
// Ports:
//   clk, reset  : 50 MHz system clock, asynchronous active-high reset
//   start       : burst request, sampled only in IDLE
//   half_div    : SCLK half-period in clk cycles (0 behaves as 1)
//   nbits       : SCLK cycles per burst
//   cpol, cpha  : SPI mode
//   abort       : (SPI_SCLK_ABORT_EN only) terminate the running burst
//   sclk        : serial clock
//   shift_stb   : drive next MOSI bit
//   sample_stb  : capture MISO
//   busy, done  : burst in progress / one-cycle end-of-burst pulse
// -----------------------------------------------------------------------------
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CNT_W  = SPI_CNT_W_DEF,
    parameter int BITS_W = SPI_BITS_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  half_div,
    input  logic [BITS_W-1:0] nbits,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_SCLK_ABORT_EN
    input  logic              abort,
`endif
    output logic              sclk,
    output logic              shift_stb,
    output logic              sample_stb,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BITS_W:0]  EDGE_ONE = {{BITS_W{1'b0}}, 1'b1};

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  h_last_q, h_last_d;
    logic [BITS_W-1:0] n_q, n_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [BITS_W:0]   edge_q, edge_d;
    logic              sclk_q, sclk_d;
    logic              shift_q, shift_d;
    logic              sample_q, sample_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              half_tc;
    logic [BITS_W:0]   edge_nxt;
    logic [BITS_W:0]   last_edge;
    logic              leading;

    spi_half_period_counter #(
        .CNT_W (CNT_W)
    ) u_half_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == IDLE),
        .en    (state_q != IDLE),
        .last  (h_last_q),
        .tc    (half_tc)
    );

    always_comb begin
        state_d   = state_q;
        h_last_d  = h_last_q;
        n_d       = n_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        edge_d    = edge_q;
        sclk_d    = sclk_q;
        shift_d   = 1'b0;
        sample_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // Number of the edge about to occur; odd numbers are leading edges.
        edge_nxt  = edge_q + EDGE_ONE;
        last_edge = {n_q, 1'b0};
        leading   = edge_nxt[0];

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                busy_d = 1'b0;
                if (start) begin
                    h_last_d = (half_div == '0) ? '0 : (half_div - CNT_ONE);
                    n_d      = nbits;
                    cpol_d   = cpol;
                    cpha_d   = cpha;
                    edge_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (n_q == '0) begin
                    // Empty burst finishes one cycle after acceptance.
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (half_tc) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt;
                    if (cpha_q) begin
                        shift_d  = leading;
                        sample_d = ~leading;
                    end else begin
                        sample_d = leading;
                        // No further bit to drive after the final trailing edge.
                        shift_d  = ~leading && (edge_nxt != last_edge);
                    end
                    if (edge_nxt == last_edge) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (half_tc) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SPI_SCLK_ABORT_EN
        // Abort wins over any edge due in the same cycle.
        if (abort && (state_q != IDLE)) begin
            sclk_d   = cpol_q;
            shift_d  = 1'b0;
            sample_d = 1'b0;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            h_last_q <= '0;
            n_q      <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            edge_q   <= '0;
            sclk_q   <= 1'b0;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_last_q <= h_last_d;
            n_q      <= n_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            edge_q   <= edge_d;
            sclk_q   <= sclk_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sclk       = sclk_q;
    assign shift_stb  = shift_q;
    assign sample_stb = sample_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_sclk_gen
// Directed bench for spi_sclk_gen: a table of burst configurations with
// hand-computed edge/strobe timing, plus hand-written sequences for start
// while busy, back-to-back start in the done cycle, reset mid-burst and
// (with SPI_SCLK_ABORT_EN) abort. Times t are clock edges after the start
// acceptance edge t=0.
// -----------------------------------------------------------------------------
module tb_spi_sclk_gen;

    localparam int BUDGET = 200;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] half_div;
    logic [5:0] nbits;
    logic       cpol;
    logic       cpha;
`ifdef SPI_SCLK_ABORT_EN
    logic       abort;
`endif
    logic       sclk;
    logic       shift_stb;
    logic       sample_stb;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    spi_sclk_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .half_div   (half_div),
        .nbits      (nbits),
        .cpol       (cpol),
        .cpha       (cpha),
`ifdef SPI_SCLK_ABORT_EN
        .abort      (abort),
`endif
        .sclk       (sclk),
        .shift_stb  (shift_stb),
        .sample_stb (sample_stb),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [7:0] half_div;
        logic [5:0] nbits;
        int         done_t;
        int         toggles;
        int         n_sh;
        int         first_sh;
        int         last_sh;
        int         n_sa;
        int         first_sa;
        int         last_sa;
        logic       sclk_end;
    } vec_t;

    typedef struct {
        int   done_t;
        int   toggles;
        int   n_sh;
        int   first_sh;
        int   last_sh;
        int   n_sa;
        int   first_sa;
        int   last_sa;
        int   overlap;
        int   busy_bad;
        logic sclk_end;
    } res_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Apply a configuration and issue start so that the next posedge is t=0.
    task automatic launch(input string name, input vec_t v, input bit idle_wait);
        cpol     = v.cpol;
        cpha     = v.cpha;
        half_div = v.half_div;
        nbits    = v.nbits;
        if (idle_wait) begin
            cycle();
            cycle();
            chk({name, " idle_sclk"}, int'(sclk), int'(v.cpol));
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk({name, " busy_t0"}, int'(busy), 1);
    endtask

    // Observe t=1.. until done (or budget); returns at the done cycle.
    task automatic measure(input int start_pulse_t, output res_t r);
        logic prev;
        prev       = sclk;
        r.done_t   = -1;
        r.toggles  = 0;
        r.n_sh     = 0;
        r.first_sh = -1;
        r.last_sh  = -1;
        r.n_sa     = 0;
        r.first_sa = -1;
        r.last_sa  = -1;
        r.overlap  = 0;
        r.busy_bad = 0;
        for (int t = 1; t <= BUDGET; t++) begin
            start = (t == start_pulse_t);
            cycle();
            start = 1'b0;
            if (sclk != prev) r.toggles++;
            prev = sclk;
            if (shift_stb) begin
                r.n_sh++;
                if (r.first_sh < 0) r.first_sh = t;
                r.last_sh = t;
            end
            if (sample_stb) begin
                r.n_sa++;
                if (r.first_sa < 0) r.first_sa = t;
                r.last_sa = t;
            end
            if (shift_stb && sample_stb) r.overlap++;
            if (done) begin
                r.done_t = t;
                if (busy) r.busy_bad++;
                break;
            end
            if (!busy) r.busy_bad++;
        end
        r.sclk_end = sclk;
    endtask

    task automatic chk_res(input string name, input res_t r, input vec_t v);
        chk({name, " done_t"},   r.done_t,   v.done_t);
        chk({name, " toggles"},  r.toggles,  v.toggles);
        chk({name, " n_shift"},  r.n_sh,     v.n_sh);
        chk({name, " first_sh"}, r.first_sh, v.first_sh);
        chk({name, " last_sh"},  r.last_sh,  v.last_sh);
        chk({name, " n_sample"}, r.n_sa,     v.n_sa);
        chk({name, " first_sa"}, r.first_sa, v.first_sa);
        chk({name, " last_sa"},  r.last_sa,  v.last_sa);
        chk({name, " overlap"},  r.overlap,  0);
        chk({name, " busy"},     r.busy_bad, 0);
        chk({name, " sclk_end"}, int'(r.sclk_end), int'(v.sclk_end));
    endtask

    task automatic run_row(input int i);
        res_t  r;
        string name;
        name = $sformatf("row%0d", i);
        launch(name, vecs[i], 1'b1);
        measure(-1, r);
        chk_res(name, r, vecs[i]);
        cycle();
        chk({name, " done_clear"}, int'(done), 0);
        chk({name, " busy_idle"},  int'(busy), 0);
    endtask

    initial begin
        vec_t v;
        vec_t v2;
        res_t r;

        //          cpol  cpha  H      N      done tog  nsh fsh lsh  nsa fsa lsa  end
        vecs[0] = '{1'b0, 1'b0, 8'd3, 6'd8,  51,  16,  7,  6,  42,  8,  3,  45, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'd2, 6'd8,  34,  16,  8,  2,  30,  8,  4,  32, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 8'd0, 6'd1,   3,   2,  0, -1,  -1,  1,  1,   1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 8'd5, 6'd0,   1,   0,  0, -1,  -1,  0, -1,  -1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'd1, 6'd3,   7,   6,  3,  1,   5,  3,  2,   6, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'd4, 6'd2,  20,   4,  1,  8,   8,  2,  4,  12, 1'b1};

        reset    = 1'b1;
        start    = 1'b0;
        half_div = 8'd0;
        nbits    = 6'd0;
        cpol     = 1'b1;
        cpha     = 1'b0;
`ifdef SPI_SCLK_ABORT_EN
        abort    = 1'b0;
`endif

        // Reset values (cpol=1 would show if sclk were not held at 0).
        @(negedge clk);
        @(negedge clk);
        chk("rst sclk",   int'(sclk),       0);
        chk("rst shift",  int'(shift_stb),  0);
        chk("rst sample", int'(sample_stb), 0);
        chk("rst busy",   int'(busy),       0);
        chk("rst done",   int'(done),       0);
        reset = 1'b0;
        cycle();
        chk("idle follows cpol", int'(sclk), 1);

        for (int i = 0; i < 6; i++) begin
            run_row(i);
        end

        // Start pulse mid-burst is ignored; a start held into the done cycle
        // begins a second burst.
        v  = '{1'b0, 1'b0, 8'd2, 6'd4, 18, 8, 3, 4, 12, 4, 2, 14, 1'b0};
        launch("ign", v, 1'b1);
        measure(5, r);
        chk_res("ign", r, v);
        v2 = '{1'b0, 1'b0, 8'd1, 6'd2, 5, 4, 1, 2, 2, 2, 1, 3, 1'b0};
        launch("b2b", v2, 1'b0);
        chk("b2b done_low", int'(done), 0);
        measure(-1, r);
        chk_res("b2b", r, v2);
        cycle();
        chk("b2b done_clear", int'(done), 0);

        // Reset mid-burst: outputs clear immediately, no done pulse.
        v = '{1'b0, 1'b0, 8'd2, 6'd8, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0};
        launch("rmid", v, 1'b1);
        repeat (6) cycle();
        chk("rmid sclk_t6", int'(sclk), 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rmid sclk",   int'(sclk),       0);
        chk("rmid shift",  int'(shift_stb),  0);
        chk("rmid sample", int'(sample_stb), 0);
        chk("rmid busy",   int'(busy),       0);
        chk("rmid done",   int'(done),       0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rmid no_done", int'(done), 0);
        end
        reset = 1'b0;
        run_row(2);

`ifdef SPI_SCLK_ABORT_EN
        // Abort in IDLE does nothing.
        abort = 1'b1;
        cycle();
        cycle();
        chk("abort idle busy", int'(busy), 0);
        chk("abort idle done", int'(done), 0);
        abort = 1'b0;
        // Abort sampled at t=10 pre-empts leading edge 5.
        v = '{1'b0, 1'b0, 8'd2, 6'd8, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0};
        launch("abort", v, 1'b1);
        repeat (9) cycle();
        chk("abort sclk_t9", int'(sclk), 0);
        chk("abort busy_t9", int'(busy), 1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort sclk",   int'(sclk),       0);
        chk("abort done",   int'(done),       1);
        chk("abort busy",   int'(busy),       0);
        chk("abort sample", int'(sample_stb), 0);
        chk("abort shift",  int'(shift_stb),  0);
        cycle();
        chk("abort done_clear", int'(done), 0);
        chk("abort stay_idle",  int'(busy), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
